// File: rtl/parking_lot_if.sv
// Parking-lot controller bus.
// Carries gate requests (enter/exit/exit_spot/clr_err) from the sensor/keypad
// side and occupancy, door, error and parked-time status back to the
// display/billing side.
//   master : gate side. Drives the requests and reads the status.
//   slave  : controller. Reads the requests and drives the status.
interface parking_lot_if #(
  parameter int NUM_SPOTS = 8,
  parameter int SPOT_W    = 3,
  parameter int CAP_W     = 4,
  parameter int TIME_W    = 32
);
  logic                              enter;
  logic                              exit;
  logic [SPOT_W-1:0]                 exit_spot;
  logic                              clr_err;
  logic [NUM_SPOTS-1:0]              F;
  logic [SPOT_W-1:0]                 L;
  logic [CAP_W-1:0]                  capacity;
  logic                              full;
  logic                              empty;
  logic                              door_open;
  logic                              busy;
  logic [3:0]                        E;
  logic [TIME_W-1:0]                 last_time;
  // Spot i sits at bits [i*TIME_W +: TIME_W].
  logic [NUM_SPOTS-1:0][TIME_W-1:0]  spot_time;

  modport master (
    output enter, exit, exit_spot, clr_err,
    input  F, L, capacity, full, empty, door_open, busy, E, last_time, spot_time
  );

  modport slave (
    input  enter, exit, exit_spot, clr_err,
    output F, L, capacity, full, empty, door_open, busy, E, last_time, spot_time
  );
endinterface

// File: rtl/parking_lot_ctrl.sv
// parking_lot_ctrl: occupancy tracker and door sequencer for NUM_SPOTS spots.
// An entry takes the lowest free spot. An exit frees spot exit_spot and reports
// how long that spot was parked. Each accepted event holds the door open for
// DOOR_HOLD cycles. While the door is open, new requests are dropped and flagged.
// Ports:
//   CLK, RST : clock (rising edge) and asynchronous active-high reset.
//   bus      : parking_lot_if.slave.
//              In:  enter, exit, exit_spot, clr_err.
//              Out: F, L, capacity, full, empty, door_open, busy,
//                   E (sticky: [0] entry while full, [1] bad exit,
//                      [2] request dropped, [3] timer saturated),
//                   last_time, spot_time.
module parking_lot_ctrl #(
  parameter int NUM_SPOTS = 8,
  parameter int SPOT_W    = 3,
  parameter int CAP_W     = 4,
  parameter int TIME_W    = 32,
  parameter int DOOR_HOLD = 4
) (
  input  logic         CLK,
  input  logic         RST,
  parking_lot_if.slave bus
);

  typedef enum logic {S_IDLE, S_DOOR} state_t;

  localparam int                 DT_W    = (DOOR_HOLD > 1) ? $clog2(DOOR_HOLD) : 1;
  localparam logic [DT_W-1:0]    DT_LOAD = DT_W'(DOOR_HOLD - 1);
  localparam logic [CAP_W-1:0]   CAP_MAX = CAP_W'(NUM_SPOTS);
  localparam logic [SPOT_W:0]    NS_IDX  = (SPOT_W+1)'(NUM_SPOTS);
  // One below all-ones: the increment that lands on the ceiling raises E[3] once.
  localparam logic [TIME_W-1:0]  T_PRE   = {{(TIME_W-1){1'b1}}, 1'b0};

  state_t                            r_state, w_state_nxt;
  logic [NUM_SPOTS-1:0]              r_F, w_F_nxt;
  logic [SPOT_W-1:0]                 r_L, w_L_nxt;
  logic [3:0]                        r_E, w_E_nxt;
  logic [DT_W-1:0]                   r_dtmr, w_dtmr_nxt;
  logic [TIME_W-1:0]                 r_last, w_last_nxt;
  logic [NUM_SPOTS-1:0][TIME_W-1:0]  r_time;

  logic [NUM_SPOTS-1:0]              w_clr;      // zero that spot's timer this edge
  logic [NUM_SPOTS-1:0]              w_free;
  logic [SPOT_W-1:0]                 w_lo_idx;
  logic                              w_lo_found;
  logic                              w_exit_ok;
  logic                              w_enter_ok;
  logic                              w_in_range;
  logic [CAP_W-1:0]                  w_occ_cnt;

  assign w_in_range = ({1'b0, bus.exit_spot} < NS_IDX);

  // Per-spot parked-time counters. A spot that is being taken or vacated
  // restarts at 0; an empty spot holds 0; an occupied one counts and saturates.
  for (genvar i = 0; i < NUM_SPOTS; i++) begin : g_spot
    always_ff @(posedge CLK or posedge RST) begin
      if (RST)                          r_time[i] <= '0;
      else if (w_clr[i] || !r_F[i])     r_time[i] <= '0;
      else if (r_time[i] != '1)         r_time[i] <= r_time[i] + 1'b1;
    end
  end

  // Next-state / datapath decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_F_nxt     = r_F;
    w_L_nxt     = r_L;
    w_dtmr_nxt  = r_dtmr;
    w_last_nxt  = r_last;
    w_clr       = '0;
    w_free      = '0;
    w_lo_idx    = '0;
    w_lo_found  = 1'b0;
    w_exit_ok   = 1'b0;
    w_enter_ok  = 1'b0;
    // Clear first, so an error raised in the same cycle survives the clear.
    w_E_nxt     = bus.clr_err ? 4'b0000 : r_E;

    case (r_state)
      S_IDLE: begin
        if (bus.exit) begin
          if (w_in_range && r_F[bus.exit_spot]) begin
            w_exit_ok               = 1'b1;
            w_F_nxt[bus.exit_spot]  = 1'b0;
            w_last_nxt              = r_time[bus.exit_spot];
            w_clr[bus.exit_spot]    = 1'b1;
          end else begin
            w_E_nxt[1] = 1'b1;
          end
        end
        if (bus.enter) begin
          // The free mask already includes a spot vacated this cycle.
          w_free = ~w_F_nxt;
          // Scan downward so the final hit is the lowest free index.
          for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
            if (w_free[i]) begin
              w_lo_found = 1'b1;
              w_lo_idx   = SPOT_W'(i);
            end
          end
          if (w_lo_found) begin
            w_enter_ok          = 1'b1;
            w_F_nxt[w_lo_idx]   = 1'b1;
            w_L_nxt             = w_lo_idx;
            w_clr[w_lo_idx]     = 1'b1;
          end else begin
            w_E_nxt[0] = 1'b1;
          end
        end
        if (w_exit_ok || w_enter_ok) begin
          w_state_nxt = S_DOOR;
          w_dtmr_nxt  = DT_LOAD;
        end
      end
      S_DOOR: begin
        // Requests are dropped here and do not extend the hold time.
        if (bus.enter || bus.exit) w_E_nxt[2] = 1'b1;
        if (r_dtmr == '0) w_state_nxt = S_IDLE;
        else              w_dtmr_nxt  = r_dtmr - 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    for (int i = 0; i < NUM_SPOTS; i++) begin
      if (r_F[i] && !w_clr[i] && (r_time[i] == T_PRE)) w_E_nxt[3] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_F     <= '0;
      r_L     <= '0;
      r_E     <= '0;
      r_dtmr  <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_F     <= w_F_nxt;
      r_L     <= w_L_nxt;
      r_E     <= w_E_nxt;
      r_dtmr  <= w_dtmr_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_occ_cnt = '0;
    for (int i = 0; i < NUM_SPOTS; i++) w_occ_cnt = w_occ_cnt + CAP_W'(r_F[i]);
  end

  assign bus.F         = r_F;
  assign bus.L         = r_L;
  assign bus.E         = r_E;
  assign bus.last_time = r_last;
  assign bus.spot_time = r_time;
  assign bus.capacity  = CAP_MAX - w_occ_cnt;
  assign bus.full      = (bus.capacity == '0);
  assign bus.empty     = (bus.capacity == CAP_MAX);
  assign bus.door_open = (r_state == S_DOOR);
  assign bus.busy      = (r_state == S_DOOR);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
module tb_parking_lot_ctrl;
  localparam int NS = 4, SW = 2, CW = 3, TW = 8, DH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  parking_lot_if #(.NUM_SPOTS(NS), .SPOT_W(SW), .CAP_W(CW), .TIME_W(TW)) bus ();

  parking_lot_ctrl #(
    .NUM_SPOTS(NS), .SPOT_W(SW), .CAP_W(CW), .TIME_W(TW), .DOOR_HOLD(DH)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.enter = 1'b0; bus.exit = 1'b0; bus.exit_spot = '0; bus.clr_err = 1'b0;

    // Reset state
    tick(2);
    chk("rst_F",     64'(bus.F), 64'h0);
    chk("rst_cap",   64'(bus.capacity), 64'd4);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full",  64'(bus.full), 64'd0);
    chk("rst_door",  64'(bus.door_open), 64'd0);
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_E",     64'(bus.E), 64'h0);
    chk("rst_L",     64'(bus.L), 64'h0);
    chk("rst_last",  64'(bus.last_time), 64'h0);
    rst = 1'b0;
    tick(1);
    chk("idle_door", 64'(bus.door_open), 64'd0);

    // Single entry: spot 0, door open exactly 3 cycles
    bus.enter = 1'b1; tick(1); bus.enter = 1'b0;
    chk("e1_F",     64'(bus.F), 64'b0001);
    chk("e1_L",     64'(bus.L), 64'd0);
    chk("e1_cap",   64'(bus.capacity), 64'd3);
    chk("e1_empty", 64'(bus.empty), 64'd0);
    chk("e1_door0", 64'(bus.door_open), 64'd1);
    chk("e1_busy",  64'(bus.busy), 64'd1);
    chk("e1_t0",    64'(bus.spot_time[0]), 64'd0);
    tick(1);
    chk("e1_door1", 64'(bus.door_open), 64'd1);
    chk("e1_t1",    64'(bus.spot_time[0]), 64'd1);
    tick(1);
    chk("e1_door2", 64'(bus.door_open), 64'd1);
    tick(1);
    chk("e1_door3", 64'(bus.door_open), 64'd0);
    chk("e1_busy3", 64'(bus.busy), 64'd0);
    chk("e1_t3",    64'(bus.spot_time[0]), 64'd3);

    // Fill spots 1..3
    for (int k = 1; k < NS; k++) begin
      bus.enter = 1'b1; tick(1); bus.enter = 1'b0;
      chk("fill_L", 64'(bus.L), 64'(k));
      tick(3);
    end
    chk("fill_F",    64'(bus.F), 64'b1111);
    chk("fill_full", 64'(bus.full), 64'd1);
    chk("fill_cap",  64'(bus.capacity), 64'd0);

    // Fifth entry while full
    bus.enter = 1'b1; tick(1); bus.enter = 1'b0;
    chk("e5_E",    64'(bus.E), 64'b0001);
    chk("e5_F",    64'(bus.F), 64'b1111);
    chk("e5_door", 64'(bus.door_open), 64'd0);
    chk("e5_L",    64'(bus.L), 64'd3);

    bus.clr_err = 1'b1; tick(1); bus.clr_err = 1'b0;
    chk("clr1_E", 64'(bus.E), 64'h0);

    // Simultaneous enter + exit(2) while full: car takes spot 2
    bus.enter = 1'b1; bus.exit = 1'b1; bus.exit_spot = 2'd2;
    tick(1);
    bus.enter = 1'b0; bus.exit = 1'b0;
    chk("ee_F",    64'(bus.F), 64'b1111);
    chk("ee_L",    64'(bus.L), 64'd2);
    chk("ee_cap",  64'(bus.capacity), 64'd0);
    chk("ee_E",    64'(bus.E), 64'h0);
    chk("ee_door", 64'(bus.door_open), 64'd1);
    chk("ee_t2",   64'(bus.spot_time[2]), 64'd0);
    tick(3);
    chk("ee_door_end", 64'(bus.door_open), 64'd0);

    // Free spot 1, re-park there, exit after 10 cycles
    bus.exit = 1'b1; bus.exit_spot = 2'd1; tick(1); bus.exit = 1'b0;
    chk("x1_F",   64'(bus.F), 64'b1101);
    chk("x1_cap", 64'(bus.capacity), 64'd1);
    tick(3);
    bus.enter = 1'b1; tick(1); bus.enter = 1'b0;
    chk("p1_L",  64'(bus.L), 64'd1);
    chk("p1_F",  64'(bus.F), 64'b1111);
    chk("p1_t0", 64'(bus.spot_time[1]), 64'd0);
    tick(10);
    chk("p1_t10", 64'(bus.spot_time[1]), 64'd10);
    bus.exit = 1'b1; bus.exit_spot = 2'd1; tick(1); bus.exit = 1'b0;
    chk("x10_last", 64'(bus.last_time), 64'd10);
    chk("x10_F",    64'(bus.F), 64'b1101);
    chk("x10_t1",   64'(bus.spot_time[1]), 64'd0);
    chk("x10_door", 64'(bus.door_open), 64'd1);

    // Enter during DOOR: dropped, hold not extended
    bus.enter = 1'b1; tick(1); bus.enter = 1'b0;
    chk("drop_E",    64'(bus.E), 64'b0100);
    chk("drop_F",    64'(bus.F), 64'b1101);
    chk("drop_door", 64'(bus.door_open), 64'd1);
    tick(1);
    chk("drop_door2", 64'(bus.door_open), 64'd1);
    tick(1);
    chk("drop_door3", 64'(bus.door_open), 64'd0);

    // Exit from an empty spot
    bus.exit = 1'b1; bus.exit_spot = 2'd1; tick(1); bus.exit = 1'b0;
    chk("bad_E",    64'(bus.E), 64'b0110);
    chk("bad_F",    64'(bus.F), 64'b1101);
    chk("bad_door", 64'(bus.door_open), 64'd0);
    chk("bad_last", 64'(bus.last_time), 64'd10);

    bus.clr_err = 1'b1; tick(1); bus.clr_err = 1'b0;
    chk("clr2_E", 64'(bus.E), 64'h0);

    // Long park: timers saturate, E[3] raised once
    bus.enter = 1'b1; tick(1); bus.enter = 1'b0;
    chk("sat_L", 64'(bus.L), 64'd1);
    tick(300);
    chk("sat_t1", 64'(bus.spot_time[1]), 64'd255);
    chk("sat_t0", 64'(bus.spot_time[0]), 64'd255);
    chk("sat_E",  64'(bus.E), 64'b1000);
    bus.clr_err = 1'b1; tick(1); bus.clr_err = 1'b0;
    chk("sat_clr_E", 64'(bus.E), 64'h0);
    tick(2);
    chk("sat_hold_E", 64'(bus.E), 64'h0);
    chk("sat_hold_t", 64'(bus.spot_time[1]), 64'd255);

    // clr_err together with a new error: the error wins
    bus.clr_err = 1'b1; bus.enter = 1'b1; tick(1);
    bus.clr_err = 1'b0; bus.enter = 1'b0;
    chk("clrwin_E", 64'(bus.E), 64'b0001);
    chk("clrwin_F", 64'(bus.F), 64'b1111);

    // Asynchronous reset while the door is open
    bus.exit = 1'b1; bus.exit_spot = 2'd0; tick(1); bus.exit = 1'b0;
    chk("ar_pre_door", 64'(bus.door_open), 64'd1);
    chk("ar_pre_last", 64'(bus.last_time), 64'd255);
    #2 rst = 1'b1;
    #1;
    chk("ar_door", 64'(bus.door_open), 64'd0);
    chk("ar_busy", 64'(bus.busy), 64'd0);
    chk("ar_F",    64'(bus.F), 64'h0);
    chk("ar_E",    64'(bus.E), 64'h0);
    chk("ar_cap",  64'(bus.capacity), 64'd4);
    chk("ar_t3",   64'(bus.spot_time[3]), 64'd0);
    chk("ar_last", 64'(bus.last_time), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("post_door", 64'(bus.door_open), 64'd0);
    chk("post_F",    64'(bus.F), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
